// File: rtl/ll_detector.sv
// Threshold/persistence seizure detector on the line-length feature stream.
// Raises seizure after a run of exceedances and emits an event record (peak, length) via valid/ready.
module ll_detector #(
    parameter int unsigned data_width = 25,
    parameter int unsigned cnt_width  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic signed [data_width-1:0] din,
    input  logic                         din_valid,
    input  logic        [data_width-2:0] thr,
    input  logic        [cnt_width-1:0]  n_consec,
    input  logic        [cnt_width-1:0]  hold_len,
    output logic                         seizure,
    output logic        [1:0]            state_dbg,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic signed [data_width-1:0] evt_peak,
    output logic        [cnt_width-1:0]  evt_len,
    output logic                         evt_ovf
);

    localparam int unsigned cw1 = cnt_width + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMING = 2'd1,
        ALARM  = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t                       state;
    logic        [cnt_width-1:0]  cnt;
    logic        [cnt_width-1:0]  hcnt;
    logic        [cnt_width-1:0]  len;
    logic signed [data_width-1:0] peak;

    logic                         accept;
    logic                         exceed;
    logic        [cnt_width-1:0]  nc_eff;
    logic        [cnt_width-1:0]  len_inc;
    logic signed [data_width-1:0] peak_max;
    logic                         arm_done;
    logic                         end_evt;

    // Sample qualification and per-sample helper values
    always_comb begin
        accept   = din_valid && !en;
        exceed   = din > $signed({1'b0, thr});
        nc_eff   = (n_consec == '0) ? cnt_width'(1) : n_consec;
        len_inc  = (len == {cnt_width{1'b1}}) ? len : len + cnt_width'(1);
        peak_max = (din > peak) ? din : peak;
        arm_done = (cw1'(cnt) + cw1'(1)) >= cw1'(nc_eff);
        end_evt  = 1'b0;
        if (accept && !exceed) begin
            if (state == ALARM && hold_len <= cnt_width'(1))
                end_evt = 1'b1;
            else if (state == HOLD && hcnt <= cnt_width'(1))
                end_evt = 1'b1;
        end
    end

    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hcnt      <= '0;
            len       <= '0;
            peak      <= '0;
            seizure   <= 1'b0;
            evt_valid <= 1'b0;
            evt_peak  <= '0;
            evt_len   <= '0;
            evt_ovf   <= 1'b0;
        end else begin
            // Record handshake runs regardless of the enable
            if (end_evt) begin
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_peak  <= peak_max;
                    evt_len   <= len_inc;
                end else begin
                    evt_ovf <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (accept) begin
                case (state)
                    IDLE: begin
                        if (exceed) begin
                            cnt <= cnt_width'(1);
                            if (nc_eff == cnt_width'(1)) begin
                                state   <= ALARM;
                                peak    <= din;
                                len     <= cnt_width'(1);
                                seizure <= 1'b1;
                            end else begin
                                state <= ARMING;
                            end
                        end
                    end
                    ARMING: begin
                        if (exceed) begin
                            cnt <= cnt + cnt_width'(1);
                            if (arm_done) begin
                                state   <= ALARM;
                                peak    <= din;
                                len     <= cnt_width'(1);
                                seizure <= 1'b1;
                            end
                        end else begin
                            cnt   <= '0;
                            state <= IDLE;
                        end
                    end
                    ALARM: begin
                        len  <= len_inc;
                        peak <= peak_max;
                        if (end_evt) begin
                            state   <= IDLE;
                            seizure <= 1'b0;
                            cnt     <= '0;
                        end else if (!exceed) begin
                            hcnt  <= hold_len - cnt_width'(1);
                            state <= HOLD;
                        end
                    end
                    HOLD: begin
                        len  <= len_inc;
                        peak <= peak_max;
                        if (exceed) begin
                            state <= ALARM;
                        end else if (end_evt) begin
                            state   <= IDLE;
                            seizure <= 1'b0;
                            cnt     <= '0;
                        end else begin
                            hcnt <= hcnt - cnt_width'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ll_detector.md
# ll_detector

Threshold/persistence detector that sits downstream of the line-length datapath and consumes its feature stream. It accepts one line-length value per `din_valid` pulse, compares it with a programmable threshold, raises `seizure` after a run of consecutive exceedances, and keeps it raised through a hold-off window. At the end of each event it presents a one-entry event record (peak value, duration) to the controller over a valid/ready handshake.

## Interface
- `data_width`, 25: width of the signed line-length input.
- `cnt_width`, 8: width of the persistence, hold and length counters.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-low reset.
- `en` in 1: active-low enable. When high, samples are ignored and FSM and counters freeze. The event handshake keeps operating.
- `din` in `data_width`, signed: line-length value.
- `din_valid` in 1: one-cycle strobe marking a new `din`. Driven from the datapath `data_valid`.
- `thr` in `data_width-1`, unsigned: detection threshold. Sampled on every accepted sample.
- `n_consec` in `cnt_width`: exceedances required to alarm. Value 0 is treated as 1.
- `hold_len` in `cnt_width`: consecutive non-exceeding samples needed to end an event.
- `seizure` out 1: detection level.
- `state_dbg` out 2: current FSM state encoding.
- `evt_valid` out 1: event record available.
- `evt_ready` in 1: controller accepts the record.
- `evt_peak` out `data_width`, signed: maximum `din` during the event.
- `evt_len` out `cnt_width`: number of accepted samples in the event, saturating.
- `evt_ovf` out 1: sticky flag, set when an event record is dropped.

## Operation
- **Accepted sample:** `din_valid==1 && en==0`. Nothing else advances the FSM or the counters.
- **exceed:** `din > {1'b0,thr}` (signed compare). Equality does not exceed. Negative `din` never exceeds.
- **States:** IDLE=0, ARMING=1, ALARM=2, HOLD=3.
- **IDLE:**
  - exceed: `cnt`=1. If `n_consec`≤1, go to ALARM; otherwise go to ARMING.
  - no exceed: stay.
- **ARMING:**
  - exceed: `cnt`+1. If `cnt`+1 ≥ `n_consec`, go to ALARM.
  - no exceed: `cnt`=0, go to IDLE.
- **Entering ALARM:** `peak`=`din`, `len`=1. `seizure`=1 throughout ALARM and HOLD.
- **ALARM, on each accepted sample:** `len`+1 (saturating at all-ones), `peak`=max(`peak`,`din`).
  - no exceed with `hold_len`==0: event ends.
  - no exceed with `hold_len`>0: `hcnt`=`hold_len`-1; if `hcnt` becomes 0, the event ends; otherwise go to HOLD.
- **HOLD, on each accepted sample:** `len`+1 and `peak` update continue.
  - exceed: go to ALARM.
  - no exceed: `hcnt`-1; the event ends when it reaches 0.
- **Event end:** go to IDLE, `seizure`=0, `cnt`=0.
  - If `evt_valid==0`, load `evt_peak`/`evt_len` and set `evt_valid`.
  - If `evt_valid==1` and not handshaking this cycle, discard the record and set `evt_ovf`.
  - If a handshake completes in the same cycle as an event end, the new record is loaded (no overflow).
- **Handshake:**
  - `evt_valid` falls the cycle after `evt_valid && evt_ready`.
  - `evt_peak`/`evt_len` stay stable while `evt_valid` is high.
  - `evt_ovf` clears only on reset.
- **Threshold changes:** `thr`, `n_consec` and `hold_len` may change at any time; they take effect on the next accepted sample.

## Timing
- **Reset** (`rst==0` at a clock edge): state=IDLE and all counters 0. `seizure`, `state_dbg`, `evt_valid`, `evt_peak`, `evt_len` and `evt_ovf` are 0 the following cycle. A mid-event reset discards the event without producing a record.
- **Registered outputs:** every output is registered.
- **`seizure` rise:** the cycle after the accepted sample that completes the persistence count.
- **`seizure` fall and `evt_valid` rise:** the cycle after the accepted sample that ends the event.
- **Back-to-back `din_valid`:** valid every cycle is supported; each valid cycle is processed independently.
- **Throughput:** one accepted sample per cycle. No backpressure toward the datapath; samples are never stalled.

## Test plan
- **Persistence:** `thr`=100, `n_consec`=3, `hold_len`=2, samples 150,150,150 → `seizure` rises the cycle after the 3rd sample; `state_dbg`=2.
- **Broken run:** samples 150,150,90,150 with `n_consec`=3 → `seizure` stays 0; state returns to 0 after the 90, then to 1.
- **Full event:** samples 150,150,150,300,50,50 with `hold_len`=2 → `seizure` falls after the 2nd 50; `evt_valid`=1, `evt_peak`=300, `evt_len`=4.
- **Hold re-entry:** in HOLD, a sample of 200 returns the FSM to ALARM, `seizure` stays 1 and `len` keeps counting.
- **Overflow:** hold `evt_ready`=0 through two complete events → first record is retained and `evt_ovf`=1. Raising `evt_ready` clears `evt_valid` the next cycle.
- **Enable, equality and reset:**
  - `en`=1 with strobes → no state change.
  - `din`==`thr` → not an exceedance.
  - `rst`=0 during ALARM → all outputs 0 the next cycle and no record.
